// File: rtl/serial_rx_pkg.sv
// Shared types for the serial receiver: FSM states and parity modes.
// par_mode maps an integer parity parameter onto the XOR reference bit.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  function automatic bit par_mode(input int odd);
    return (odd != 0) ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Serial receiver bundle: rxd line in, received word and status pulses out.
// master = line driver / consumer side, slave = receiver side.
interface serial_receiver_if #(
  parameter int DATA_W = 8
);

  logic              rxd;
  logic [DATA_W-1:0] word;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output rxd,
    input  word, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  rxd,
    output word, valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for an asynchronous line that idles high.
// Ports: clk, rst (async active-low), d_i async input, q_o synced output.
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff_q <= '1;
    else      ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// Oversampling serial receiver: start/data/parity/stop framing FSM.
// Ports: clk, rst (async active-low), bus (slave: rxd in, word/status out).
module serial_receiver
  import serial_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic clk,
  input  logic rst,
  serial_receiver_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_W - 1);
  localparam logic          P_REF  = par_mode(PARITY_ODD);

  logic rxd_s;

  rx_sync #(.STAGES(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rxd),
    .q_o (rxd_s)
  );

  rx_state_e         state_q;
  logic [TW-1:0]     tmr_q;
  logic [TW-1:0]     tmr_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shf_q;
  logic [DATA_W-1:0] shf_d;
  logic [DATA_W-1:0] word_q;
  logic              rxd_prev_q;
  logic              perr_flag_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;
  logic              tick;
  logic              half;

  assign tick  = (tmr_q == T_LAST);
  assign half  = (tmr_q == T_HALF);
  assign tmr_d = tmr_q + TW'(1);

  always_comb begin
    shf_d = shf_q;
    if (MSB_FIRST != 0) shf_d = {shf_q[DATA_W-2:0], rxd_s};
    else                shf_d = {rxd_s, shf_q[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      cnt_q       <= '0;
      shf_q       <= '0;
      word_q      <= '0;
      rxd_prev_q  <= 1'b1;
      perr_flag_q <= 1'b0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rxd_prev_q <= rxd_s;
      unique case (state_q)
        IDLE: begin
          if (rxd_prev_q && !rxd_s) begin
            state_q <= START;
            tmr_q   <= '0;
          end
        end
        START: begin
          if (half) begin
            tmr_q       <= '0;
            cnt_q       <= '0;
            perr_flag_q <= 1'b0;
            // High at mid start bit: treat as a glitch.
            state_q     <= rxd_s ? IDLE : DATA;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        DATA: begin
          if (tick) begin
            tmr_q <= '0;
            shf_q <= shf_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == C_LAST)
              state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        PARITY: begin
          if (tick) begin
            tmr_q       <= '0;
            perr_flag_q <= ((^shf_q) ^ rxd_s) != P_REF;
            state_q     <= STOP;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        STOP: begin
          if (tick) begin
            tmr_q <= '0;
            if (rxd_s) begin
              word_q  <= shf_q;
              valid_q <= 1'b1;
              perr_q  <= perr_flag_q;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            tmr_q <= tmr_d;
          end
        end
        WAIT_HIGH: begin
          // Hold off until the break ends so it is not seen as a start.
          if (rxd_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.word       = word_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Randomized self-checking bench for serial_receiver.
// Three instances: MSB-first, LSB-first, MSB-first with even parity.
module tb_serial_receiver;

  localparam int CPB = 16;
  localparam int DW  = 8;

  typedef struct {
    logic [7:0] w;
    logic       pe;
    int         c;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] rx  = 3'b111;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_receiver_if #(.DATA_W(DW)) b0 ();
  serial_receiver_if #(.DATA_W(DW)) b1 ();
  serial_receiver_if #(.DATA_W(DW)) b2 ();

  assign b0.rxd = rx[0];
  assign b1.rxd = rx[1];
  assign b2.rxd = rx[2];

  serial_receiver #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .MSB_FIRST(1),
    .PARITY_EN(0), .PARITY_ODD(0)
  ) u_msb (.clk(clk), .rst(rst), .bus(b0));

  serial_receiver #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .MSB_FIRST(0),
    .PARITY_EN(0), .PARITY_ODD(0)
  ) u_lsb (.clk(clk), .rst(rst), .bus(b1));

  serial_receiver #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .MSB_FIRST(1),
    .PARITY_EN(1), .PARITY_ODD(0)
  ) u_par (.clk(clk), .rst(rst), .bus(b2));

  logic [7:0] ow [3];
  logic       ov [3];
  logic       ope[3];
  logic       ofe[3];
  logic       obs[3];

  assign ow[0] = b0.word;  assign ov[0] = b0.valid;
  assign ow[1] = b1.word;  assign ov[1] = b1.valid;
  assign ow[2] = b2.word;  assign ov[2] = b2.valid;
  assign ope[0] = b0.parity_err; assign ofe[0] = b0.frame_err;
  assign ope[1] = b1.parity_err; assign ofe[1] = b1.frame_err;
  assign ope[2] = b2.parity_err; assign ofe[2] = b2.frame_err;
  assign obs[0] = b0.busy; assign obs[1] = b1.busy;
  assign obs[2] = b2.busy;

  ev_t  vq[3][$];
  int   fcnt[3] = '{0, 0, 0};
  int   overlap = 0;
  int   dbl = 0;
  logic pv[3] = '{1'b0, 1'b0, 1'b0};
  logic pf[3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov[k]) begin
        ev_t e;
        e.w = ow[k];
        e.pe = ope[k];
        e.c = cyc;
        vq[k].push_back(e);
      end
      if (ofe[k]) fcnt[k]++;
      if (ov[k] && ofe[k]) overlap++;
      if (ope[k] && !ov[k]) overlap++;
      if ((ov[k] && pv[k]) || (ofe[k] && pf[k])) dbl++;
      pv[k] = ov[k];
      pf[k] = ofe[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line order for a byte sent MSB first: lb[i] is the i-th bit on the wire.
  function automatic logic [7:0] lbits_of(input logic [7:0] d);
    logic [7:0] lb;
    for (int i = 0; i < 8; i++) lb[i] = d[7-i];
    return lb;
  endfunction

  function automatic logic [7:0] model_word(input logic [7:0] lb,
                                            input bit msb);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) begin
      if (msb) w[7-i] = lb[i];
      else     w[i]   = lb[i];
    end
    return w;
  endfunction

  function automatic logic model_pe(input logic [7:0] lb, input logic pb,
                                    input int odd);
    int ones;
    ones = $countones(lb) + int'(pb);
    return (ones % 2) != odd;
  endfunction

  task automatic drive(input int k, input logic v, input int n);
    rx[k] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] lb, input bit pen,
                      input logic pb, input logic stopv,
                      input int stop_bits);
    drive(k, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(k, lb[i], CPB);
    if (pen) drive(k, pb, CPB);
    drive(k, stopv, CPB * stop_bits);
  endtask

  task automatic expect_good(input int k, input logic [7:0] w,
                             input logic pe, output int c);
    ev_t e;
    c = -1;
    chk("valid_count", 32'(vq[k].size()), 32'd1);
    if (vq[k].size() > 0) begin
      e = vq[k].pop_front();
      c = e.c;
      chk("word_at_valid", 32'(e.w), 32'(w));
      chk("parity_err", 32'(e.pe), 32'(pe));
    end
    vq[k].delete();
    chk("word_out", 32'(ow[k]), 32'(w));
  endtask

  logic [7:0] last_w[3] = '{8'h00, 8'h00, 8'h00};
  bit         exp_ok[3];
  logic [7:0] exp_w [3];
  logic       exp_pe[3];

  task automatic rand_frame(input int k);
    int         gap;
    logic [7:0] lb;
    logic       pb;
    bit         good;
    bit         pen;
    gap  = int'($urandom_range(0, 2));
    lb   = 8'($urandom);
    pb   = 1'($urandom);
    good = ($urandom_range(0, 7) != 0);
    pen  = (k == 2);
    if (gap > 0) drive(k, 1'b1, gap * CPB);
    send(k, lb, pen, pb, good ? 1'b1 : 1'b0, good ? 1 : 2);
    if (!good) drive(k, 1'b1, CPB);
    exp_ok[k] = good;
    exp_w[k]  = model_word(lb, k != 1);
    exp_pe[k] = pen ? model_pe(lb, pb, 0) : 1'b0;
  endtask

  initial begin
    int         c0;
    int         c1;
    int         c2;
    int         f0;
    int         fb[3];
    logic [7:0] lb;
    ev_t        e;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_word", 32'(ow[k]), 32'd0);
      chk("rst_busy", 32'(obs[k]), 32'd0);
      chk("rst_valid", 32'(ov[k]), 32'd0);
    end
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 0xA5 on both bit orders with identical line bits.
    lb = lbits_of(8'hA5);
    c0 = cyc;
    fork
      send(0, lb, 1'b0, 1'b0, 1'b1, 1);
      send(1, lb, 1'b0, 1'b0, 1'b1, 1);
    join
    expect_good(0, model_word(lb, 1'b1), 1'b0, c1);
    chk("latency_ok", 32'((c1 - c0 >= 154) && (c1 - c0 <= 156)), 32'd1);
    expect_good(1, model_word(lb, 1'b0), 1'b0, c1);
    last_w[0] = 8'hA5;
    last_w[1] = model_word(lb, 1'b0);
    chk("no_ferr_a5", 32'(fcnt[0] + fcnt[1]), 32'd0);

    // Short low glitch.
    f0 = fcnt[0];
    drive(0, 1'b0, 4);
    rx[0] = 1'b1;
    chk("glitch_busy_hi", 32'(obs[0]), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_busy_lo", 32'(obs[0]), 32'd0);
    chk("glitch_no_valid", 32'(vq[0].size()), 32'd0);
    chk("glitch_no_ferr", 32'(fcnt[0] - f0), 32'd0);

    // Framing error with a held-low stop, then recovery.
    f0 = fcnt[0];
    send(0, lbits_of(8'h3C), 1'b0, 1'b0, 1'b0, 3);
    chk("ferr_pulse", 32'(fcnt[0] - f0), 32'd1);
    chk("ferr_no_valid", 32'(vq[0].size()), 32'd0);
    chk("ferr_word_kept", 32'(ow[0]), 32'(last_w[0]));
    chk("ferr_wait_busy", 32'(obs[0]), 32'd1);
    drive(0, 1'b1, CPB);
    chk("ferr_idle_after", 32'(obs[0]), 32'd0);
    send(0, lbits_of(8'h55), 1'b0, 1'b0, 1'b1, 1);
    expect_good(0, 8'h55, 1'b0, c1);
    last_w[0] = 8'h55;

    // Even parity on 0x3C.
    lb = lbits_of(8'h3C);
    send(2, lb, 1'b1, 1'b1, 1'b1, 1);
    expect_good(2, 8'h3C, model_pe(lb, 1'b1, 0), c1);
    send(2, lb, 1'b1, 1'b0, 1'b1, 1);
    expect_good(2, 8'h3C, model_pe(lb, 1'b0, 0), c1);
    last_w[2] = 8'h3C;

    // Reset during data bit 4.
    f0 = fcnt[0];
    lb = lbits_of(8'hC3);
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(0, lb[i], CPB);
    rx[0] = lb[4];
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_word", 32'(ow[0]), 32'd0);
    chk("mid_rst_busy", 32'(obs[0]), 32'd0);
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_ferr", 32'(ofe[0]), 32'd0);
    rx[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    chk("mid_rst_no_valid", 32'(vq[0].size()), 32'd0);
    chk("mid_rst_no_ferr", 32'(fcnt[0] - f0), 32'd0);
    for (int k = 0; k < 3; k++) last_w[k] = 8'h00;
    send(0, lbits_of(8'h81), 1'b0, 1'b0, 1'b1, 1);
    expect_good(0, 8'h81, 1'b0, c1);

    // Back-to-back 0x00 then 0xFF, no idle gap.
    send(0, lbits_of(8'h00), 1'b0, 1'b0, 1'b1, 1);
    send(0, lbits_of(8'hFF), 1'b0, 1'b0, 1'b1, 1);
    chk("b2b_count", 32'(vq[0].size()), 32'd2);
    if (vq[0].size() == 2) begin
      e = vq[0].pop_front();
      c1 = e.c;
      chk("b2b_first", 32'(e.w), 32'h00);
      e = vq[0].pop_front();
      c2 = e.c;
      chk("b2b_second", 32'(e.w), 32'hFF);
      chk("b2b_gap_ok",
          32'((c2 - c1 >= 10 * CPB - 1) && (c2 - c1 <= 10 * CPB + 1)),
          32'd1);
    end
    vq[0].delete();
    last_w[0] = 8'hFF;

    // Randomized frames on all three instances in parallel.
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 3; k++) fb[k] = fcnt[k];
      fork
        rand_frame(0);
        rand_frame(1);
        rand_frame(2);
      join
      for (int k = 0; k < 3; k++) begin
        if (exp_ok[k]) begin
          expect_good(k, exp_w[k], exp_pe[k], c1);
          last_w[k] = exp_w[k];
        end else begin
          chk("rnd_ferr", 32'(fcnt[k] - fb[k]), 32'd1);
          chk("rnd_ferr_no_valid", 32'(vq[k].size()), 32'd0);
          chk("rnd_ferr_word", 32'(ow[k]), 32'(last_w[k]));
          vq[k].delete();
        end
      end
    end

    chk("valid_ferr_overlap", 32'(overlap), 32'd0);
    chk("pulse_width", 32'(dbl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter DATA_W, 8, data bits per frame, legal range 5..16.
REQ-002 Parameter CLKS_PER_BIT, 16, clk cycles per serial bit, legal range 4..65535.
REQ-003 Parameter MSB_FIRST, 1, 1 = first received data bit lands in word[DATA_W-1]; 0 = first bit lands in word[0].
REQ-004 Parameter PARITY_EN, 0, 1 = one parity bit follows the data bits.
REQ-005 Parameter PARITY_ODD, 0, 1 = odd parity; 0 = even parity; ignored when PARITY_EN=0.
REQ-006 clk  input  1  single clock; every flop is in this domain.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 rxd  input  1  asynchronous serial line; idles high.
REQ-009 word  output  DATA_W  last correctly framed data word.
REQ-010 valid  output  1  one-cycle pulse when word is updated.
REQ-011 parity_err  output  1  one-cycle pulse, coincident with valid, on parity mismatch.
REQ-012 frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all references to rxd below mean the synchronized value.
REQ-015 The FSM SHALL have exactly six states: IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-016 IDLE: a 1-to-0 transition on rxd SHALL move the FSM to START and clear the bit-timer.
REQ-017 START: at bit-timer = CLKS_PER_BIT/2-1 (integer division), rxd=0 -> DATA with timer cleared; rxd=1 -> IDLE with no output pulse (glitch rejection).
REQ-018 DATA: rxd SHALL be sampled each time the timer reaches CLKS_PER_BIT-1, i.e. at the bit centre, and the timer SHALL then wrap to 0.
REQ-019 DATA shift rule: when MSB_FIRST=1, shift left and insert at bit 0; when MSB_FIRST=0, shift right and insert at bit DATA_W-1.
REQ-020 DATA exit: after exactly DATA_W samples, go to PARITY if PARITY_EN=1, else to STOP.
REQ-021 PARITY: sample one bit; error is flagged when the XOR of the data bits and the parity bit is not equal to PARITY_ODD.
REQ-022 STOP, sample = 1: word <= shift register; valid = 1 in the next cycle; parity_err = 1 in the same cycle if the error flag is set; FSM -> IDLE.
REQ-023 A word with a parity error SHALL still update word and pulse valid.
REQ-024 STOP, sample = 0: frame_err = 1 in the next cycle; word and valid unchanged; FSM -> WAIT_HIGH.
REQ-025 WAIT_HIGH: remain until rxd = 1, then -> IDLE; this prevents a break condition from being read as a start bit.
REQ-026 Back-to-back frames: a start edge arriving immediately after a good stop sample SHALL be detected; no idle bit is required.
REQ-027 valid, parity_err and frame_err SHALL never be high for more than one cycle per frame.
REQ-028 valid and frame_err SHALL never be high in the same cycle.
REQ-029 Bit-timer width SHALL be $clog2(CLKS_PER_BIT); bit-counter width SHALL be $clog2(DATA_W+1); neither counter wraps outside the cases above.
REQ-030 Latency: valid rises 1 clk after the stop-bit centre sample, which is 2 clk of synchronizer delay plus (DATA_W + PARITY_EN + 1.5) x CLKS_PER_BIT clk after the line's falling edge, within +/-1 clk.

Reset
REQ-031 On rst=0, all state SHALL clear immediately, independent of clk: FSM = IDLE, timers = 0, shift register = 0, word = 0, valid/parity_err/frame_err/busy = 0, synchronizer flops = 1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no output pulse.
REQ-033 Reset release SHALL be synchronized externally; after release, the first falling edge of rxd starts a new frame.

Structure
REQ-034 Package serial_rx_pkg SHALL hold the FSM state enum and the parity-mode constants.
REQ-035 The synchronizer SHALL be the sub-module rx_sync (parameterised stage count, default 2); all other logic stays in serial_receiver.

Verification (DATA_W=8, CLKS_PER_BIT=16 unless stated)
REQ-036 Send 0xA5 MSB-first with a good stop bit -> word=0xA5, one valid pulse, parity_err=0, frame_err=0; repeat with MSB_FIRST=0 and the same line bits -> word=0xA5 bit-reversed (0xA5).
REQ-037 Drive rxd low for 4 clk, then high -> no pulses; busy drops within 8+2 clk.
REQ-038 Send 0x3C with the stop bit held low for 3 bit times -> frame_err pulse; word keeps its previous value; the next frame, 0x55, is received only after rxd returns high.
REQ-039 PARITY_EN=1, PARITY_ODD=0: send 0x3C with parity bit 1 -> valid and parity_err together, word=0x3C; send 0x3C with parity bit 0 -> valid only.
REQ-040 Assert rst during data bit 4 of a frame -> all outputs 0 immediately; after release, send 0x81 -> word=0x81.
REQ-041 Send 0x00 and then 0xFF with no idle gap -> two valid pulses 10x16 clk apart (+/-1), word=0x00 and then word=0xFF.
